axi_lite_sram_slave: RTL
========================

# axi_lite_sram_slave

- AXI4-Lite responder backed by a word-addressed SRAM array.
- Sits at the far end of the LSU's AXI4-Lite master port.
- Serves one transaction at a time with programmable read and write latency, and returns SLVERR for out-of-window addresses.
- Used both as the real data-memory target and as a bench-configurable slave for exercising master-side handshakes.

## Interface
Parameters:
- ADDR_WIDTH, 8, word-index width; array holds 2^ADDR_WIDTH 32-bit words
- BASE, 32'h8000_0000, byte address of word 0
- READ_LATENCY, 1, cycles from AR handshake to rvalid (legal 1..15)
- WRITE_LATENCY, 1, cycles from the later of AW/W handshakes to bvalid (legal 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address accept
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data accept
- bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- bvalid  out  1  write response valid
- bready  in  1  write response accept
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address accept
- rdata  out  32  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data accept

## Operation
FSM states:
- IDLE: accepts new transactions.
- RD_WAIT: read latency count in progress.
- RD_RESP: read response held.
- WR_WAIT: write latency count in progress.
- WR_RESP: write response held.

Ready generation:
- awready = IDLE && !aw_held.
- wready = IDLE && !w_held.
- arready = IDLE && !aw_held && !w_held.
- All three are forced 0 while rst is high.

Write path:
- AW and W may handshake in either order or in the same cycle; each is latched into aw_held/w_held.
- When both are held (including same-cycle capture), the FSM goes to WR_WAIT and a counter is loaded with WRITE_LATENCY-1.

Read path:
- Arbitration in IDLE: a pending half-written write blocks AR. If AR and both AW/W are valid in the same cycle, AW/W win and arready is still 1 only when nothing is held. Resolve that case by accepting AR: read wins when no write half is held.
- A simultaneous AW+W+AR in IDLE accepts AR only; the write handshakes are deferred.
  - awready/wready are deasserted that cycle whenever arvalid=1 and neither write half is held.

Address decode:
- idx = (addr - BASE) >> 2; addr[1:0] is ignored.
- In-window means BASE <= addr < BASE + 4*2^ADDR_WIDTH.
- Out-of-window accesses give resp 2'b10, rdata 0, and no array update.

Array update and read data:
- Writes merge per byte under wstrb; strobe-clear bytes keep their old value. wstrb = 0 is OKAY with no change.
- The array is updated on the edge that enters WR_RESP.
- Read data is sampled on the edge that enters RD_RESP.

Responses:
- rvalid/bvalid stay high with stable data and resp until rready/bready.
- The FSM returns to IDLE on the handshake edge.

## Timing
- Reset values: awready/wready/arready 0 during rst, 1 in the first cycle after release. bvalid, rvalid 0; bresp, rresp 2'b00; rdata 32'h0; aw_held/w_held 0; state IDLE. Array contents are not reset.
- Reset mid-transaction: state returns to IDLE, held halves are dropped, and any pending array write is discarded.
- Read: AR handshake at edge N gives rvalid=1 in the cycle after edge N+READ_LATENCY-1 (READ_LATENCY=1 gives rvalid the cycle right after the handshake).
- Write: the later of the AW/W handshakes at edge N gives bvalid=1 after edge N+WRITE_LATENCY-1.
- Ready signals are low from the acceptance edge until the cycle after the response handshake. Minimum back-to-back read throughput is one read per READ_LATENCY+1 cycles.
- Read-after-write to the same word, issued after the B handshake, returns the merged data.

## Configuration
- Macro AXI_SRAM_SLAVE_RAND_DELAY_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on rst) advances every cycle.
  - On each transaction acceptance, lfsr[1:0] extra wait cycles (0..3) are added to the latency counter.
  - In IDLE, awready/wready/arready are additionally gated by !lfsr[7].
- When undefined: latencies are exactly READ_LATENCY/WRITE_LATENCY, the readies follow the FSM only, and no LFSR logic exists.

## Test plan
- Write/read basic: AW+W same cycle, addr 32'h8000_0010, wdata 32'hDEADBEEF, wstrb 4'hF -> bvalid one cycle later with bresp 00. Then AR same addr -> rvalid next cycle, rdata DEADBEEF, rresp 00.
- Partial strobe: write 32'h11223344 with wstrb 4'b0101 over existing 32'hDEADBEEF -> read returns 32'hDE22BE44.
- AW/W skew: W at cycle 0, AW at cycle 3 -> wready low from cycle 1 and arready low meanwhile; bvalid 1 cycle after the AW handshake.
- Backpressure: READ_LATENCY=3, rready held 0 for 5 cycles -> rvalid asserts 3 cycles after AR and stays high with stable rdata; arready 0 until after the R handshake.
- Decode error: AR at 32'h8000_0400 (ADDR_WIDTH=8) -> rresp 2'b10, rdata 0. Write to 32'h7FFF_FFFC -> bresp 2'b10, and the array is unchanged at word 255.
- Reset mid-operation: rst pulsed during WR_WAIT -> bvalid never asserts, the target word keeps its prior value, and readies are 1 the cycle after rst falls.

Source files
------------

// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave: AXI4-Lite responder backed by a word-addressed SRAM.
// Serves one transaction at a time with programmable read/write latency and
// answers SLVERR for addresses outside [BASE, BASE + 4*2^ADDR_WIDTH).
// Optional feature macro: AXI_SRAM_SLAVE_RAND_DELAY_EN adds an 8-bit LFSR that
// inserts 0..3 extra wait cycles per transaction and randomly gates the readies.
//
// Handshake rule for every channel: a transfer happens on the rising edge where
// valid and ready are both high; a raised valid holds with stable payload until
// that edge. The slave applies the same rule to bvalid/rvalid with bresp/rresp/rdata.
module axi_lite_sram_slave #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter logic [31:0] BASE          = 32'h8000_0000,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        aw_held, w_held;
  logic [31:0] waddr_q, wdata_q, raddr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  logic        idle, gate;
  logic        aw_hs, w_hs, ar_hs, wr_go;
  logic        wr_commit, rd_sample;
  logic [4:0]  extra, rd_lat, wr_lat;
  logic [31:0] waddr_eff, wdata_eff, raddr_eff;
  logic [3:0]  wstrb_eff;

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> (ADDR_WIDTH + 2)) == 32'd0);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] to_idx(input logic [31:0] a);
    return ADDR_WIDTH'((a - BASE) >> 2);
  endfunction

`ifdef AXI_SRAM_SLAVE_RAND_DELAY_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4, free-running every cycle.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign gate  = !lfsr[7];
  assign extra = {3'b000, lfsr[1:0]};
`else
  assign gate  = 1'b1;
  assign extra = 5'd0;
`endif

  assign idle = (state == IDLE);

  // A pending write half blocks AR; an arriving AR with no write half held
  // wins over fresh AW/W, which are deferred by dropping their readies.
  assign awready = !rst && idle && gate && !aw_held && (w_held || !arvalid);
  assign wready  = !rst && idle && gate && !w_held && (aw_held || !arvalid);
  assign arready = !rst && idle && gate && !aw_held && !w_held;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign wr_go = idle && (aw_held || aw_hs) && (w_held || w_hs);

  // Held halves win over the bus so the same logic serves same-cycle capture.
  assign waddr_eff = aw_held ? waddr_q : awaddr;
  assign wdata_eff = w_held ? wdata_q : wdata;
  assign wstrb_eff = w_held ? wstrb_q : wstrb;
  assign raddr_eff = idle ? araddr : raddr_q;

  assign rd_lat = 5'(READ_LATENCY - 1) + extra;
  assign wr_lat = 5'(WRITE_LATENCY - 1) + extra;

  assign bvalid = (state == WR_RESP);
  assign rvalid = (state == RD_RESP);

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; a zero latency count skips the wait state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_commit = 1'b0;
    rd_sample = 1'b0;
    case (state)
      IDLE: begin
        if (ar_hs) begin
          if (rd_lat == 5'd0) begin
            state_nxt = RD_RESP;
            rd_sample = 1'b1;
          end else begin
            state_nxt = RD_WAIT;
            cnt_nxt   = rd_lat;
          end
        end else if (wr_go) begin
          if (wr_lat == 5'd0) begin
            state_nxt = WR_RESP;
            wr_commit = 1'b1;
          end else begin
            state_nxt = WR_WAIT;
            cnt_nxt   = wr_lat;
          end
        end
      end
      RD_WAIT: begin
        if (cnt == 5'd1) begin
          state_nxt = RD_RESP;
          rd_sample = 1'b1;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      RD_RESP: if (rready) state_nxt = IDLE;
      WR_WAIT: begin
        if (cnt == 5'd1) begin
          state_nxt = WR_RESP;
          wr_commit = 1'b1;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      WR_RESP: if (bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Channel capture, held flags and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      waddr_q <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      raddr_q <= 32'h0;
      rdata   <= 32'h0;
      rresp   <= 2'b00;
      bresp   <= 2'b00;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        waddr_q <= awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (bvalid && bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (ar_hs) raddr_q <= araddr;
      if (rd_sample) begin
        if (in_win(raddr_eff)) begin
          rdata <= mem[to_idx(raddr_eff)];
          rresp <= 2'b00;
        end else begin
          rdata <= 32'h0;
          rresp <= 2'b10;
        end
      end
      if (wr_commit) bresp <= in_win(waddr_eff) ? 2'b00 : 2'b10;
    end
  end

  // Byte-merged array update; a reset on the commit edge discards the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_commit && in_win(waddr_eff)) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_eff[b]) mem[to_idx(waddr_eff)][8*b +: 8] <= wdata_eff[8*b +: 8];
      end
    end
  end

endmodule
